// File: rtl/rk_mem_pkg.sv
// Shared types and constants for the SDRAM arbiter between the 8080 CPU and the video DMA.
package rk_mem_pkg;

  localparam int CNT_W        = 4;
  localparam int DEF_MEM_LAT  = 4;
  localparam int DEF_SLOT_LEN = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    RECOVER = 3'd4
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

endpackage

// File: rtl/rk_mem_prio.sv
// Requester arming, CPU starvation counter and grant selection for the SDRAM arbiter.
module rk_mem_prio
  import rk_mem_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 3
) (
  input  logic clk50mhz,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic vid_req,
  input  logic cpu_ack,
  input  logic vid_ack,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_vid,
  output logic cpu_armed
);

  logic             cpu_armed_r;
  logic             vid_armed_r;
  logic             cpu_low_r;
  logic             vid_low_r;
  logic [CNT_W-1:0] starve_r;
  logic             cpu_elig_s;
  logic             vid_elig_s;
  logic             starve_max_s;
  logic             grant_cpu_s;

  assign cpu_elig_s   = cpu_req & cpu_armed_r;
  assign vid_elig_s   = vid_req & vid_armed_r;
  assign starve_max_s = (starve_r == CNT_W'(CPU_MAX_WAIT));
  assign grant_cpu_s  = cpu_elig_s & (~vid_elig_s | starve_max_s);
  assign grant_valid  = grant_en & (cpu_elig_s | vid_elig_s);
  assign grant_vid    = ~grant_cpu_s;
  assign cpu_armed    = cpu_armed_r;

  // A low seen at any point since the grant re-arms the requester when its ack arrives,
  // so a DMA that pulses its request mid-transaction is served again in the next slot.
  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      cpu_armed_r <= 1'b1;
      vid_armed_r <= 1'b1;
      cpu_low_r   <= 1'b0;
      vid_low_r   <= 1'b0;
    end else begin
      if (grant_valid && grant_cpu_s) cpu_low_r <= 1'b0;
      else if (!cpu_req)              cpu_low_r <= 1'b1;
      if (grant_valid && !grant_cpu_s) vid_low_r <= 1'b0;
      else if (!vid_req)               vid_low_r <= 1'b1;
      if (cpu_ack)       cpu_armed_r <= cpu_low_r | ~cpu_req;
      else if (!cpu_req) cpu_armed_r <= 1'b1;
      if (vid_ack)       vid_armed_r <= vid_low_r | ~vid_req;
      else if (!vid_req) vid_armed_r <= 1'b1;
    end
  end

  // Starvation count of video grants taken while the CPU was waiting.
  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      starve_r <= {CNT_W{1'b0}};
    end else if (!cpu_elig_s) begin
      starve_r <= {CNT_W{1'b0}};
    end else if (grant_valid) begin
      if (grant_cpu_s)        starve_r <= {CNT_W{1'b0}};
      else if (!starve_max_s) starve_r <= starve_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rk_mem_arbiter.sv
// Shares the single-port SDRAM controller between the CPU and video DMA: grant, strobe
// sequencing with fixed read latency, one-cycle ack and CPU wait generation.
module rk_mem_arbiter
  import rk_mem_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int MEM_ADDR_W   = 18,
  parameter int MEM_LAT      = DEF_MEM_LAT,
  parameter int SLOT_LEN     = DEF_SLOT_LEN,
  parameter int CPU_MAX_WAIT = 3
) (
  input  logic                  clk50mhz,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic                  cpu_ack,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_wait,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic                  vid_ack,
  output logic [7:0]            vid_rdata,
  output logic                  mem_rd,
  output logic                  mem_we_n,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [15:0]           mem_rdata
);

  state_e            state_r;
  state_e            state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nx_s;
  logic              own_vid_r;
  logic              own_vid_nx_s;
  logic              we_r;
  logic              we_nx_s;
  logic              rd_nx_s;
  logic              we_n_nx_s;
  logic              cpu_ack_nx_s;
  logic              vid_ack_nx_s;
  logic              capture_s;
  logic              grant_en_s;
  logic              grant_valid_s;
  logic              grant_vid_s;
  logic              cpu_armed_s;
  logic [ADDR_W-1:0] grant_addr_s;
  logic              unused_hi_s;

  assign grant_en_s   = (state_r == IDLE);
  assign grant_addr_s = grant_vid_s ? vid_addr : cpu_addr;
  assign cpu_wait     = cpu_req & cpu_armed_s & ~cpu_ack;
  assign unused_hi_s  = ^mem_rdata[15:8];

  rk_mem_prio #(
    .CPU_MAX_WAIT (CPU_MAX_WAIT)
  ) u_prio (
    .clk50mhz    (clk50mhz),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .vid_req     (vid_req),
    .cpu_ack     (cpu_ack),
    .vid_ack     (vid_ack),
    .grant_en    (grant_en_s),
    .grant_valid (grant_valid_s),
    .grant_vid   (grant_vid_s),
    .cpu_armed   (cpu_armed_s)
  );

  // Next state plus next values of the registered strobes; cnt is 0 in the ISSUE cycle.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r + CNT_W'(1);
    own_vid_nx_s = own_vid_r;
    we_nx_s      = we_r;
    rd_nx_s      = 1'b0;
    we_n_nx_s    = 1'b1;
    cpu_ack_nx_s = 1'b0;
    vid_ack_nx_s = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nx_s = {CNT_W{1'b0}};
        if (grant_valid_s) begin
          state_nx_s   = ISSUE;
          own_vid_nx_s = grant_vid_s;
          we_nx_s      = ~grant_vid_s & cpu_we;
          rd_nx_s      = ~we_nx_s;
          we_n_nx_s    = ~we_nx_s;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        state_nx_s = WAIT;
        rd_nx_s    = ~we_r;
      end
      WAIT: begin
        if (cnt_r == CNT_W'(MEM_LAT)) begin
          state_nx_s   = DONE;
          capture_s    = ~we_r;
          cpu_ack_nx_s = ~own_vid_r;
          vid_ack_nx_s = own_vid_r;
        end else begin
          rd_nx_s = ~we_r;
        end
      end
      DONE, RECOVER: begin
        if (cnt_r == CNT_W'(SLOT_LEN - 1)) state_nx_s = IDLE;
        else                               state_nx_s = RECOVER;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, transaction latches and all registered outputs.
  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      own_vid_r <= 1'b0;
      we_r      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_we_n  <= 1'b1;
      mem_addr  <= {MEM_ADDR_W{1'b0}};
      mem_wdata <= 8'h00;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
      vid_rdata <= 8'h00;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      own_vid_r <= own_vid_nx_s;
      we_r      <= we_nx_s;
      mem_rd    <= rd_nx_s;
      mem_we_n  <= we_n_nx_s;
      cpu_ack   <= cpu_ack_nx_s;
      vid_ack   <= vid_ack_nx_s;
      if (grant_en_s && grant_valid_s) begin
        mem_addr <= MEM_ADDR_W'(grant_addr_s);
        if (!grant_vid_s) mem_wdata <= cpu_wdata;
      end
      if (capture_s) begin
        if (own_vid_r) vid_rdata <= mem_rdata[7:0];
        else           cpu_rdata <= mem_rdata[7:0];
      end
    end
  end

endmodule
